// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter in front of the 32-word 1W2R register-file SRAM. It is
//   the only driver of SRAM write port C. It merges two write-back sources:
//     - ALU: full-word writes, high priority, no buffering.
//     - LSU: byte-masked writes, queued in a small FIFO.
//   The arbiter expands byte enables into the SRAM's active-low bit-write mask.
//   It drops writes to register 0. A starvation counter forces the LSU to win
//   when its FIFO head has waited too long.
//
// Ports
//   CLK, RESET                    clock (posedge), async active-high reset
//   ALU_VALID/READY/ADDR/DATA     ALU write-back request (valid/ready)
//   LSU_VALID/READY/ADDR/DATA/BE  LSU write-back request (valid/ready, BE active-high)
//   WEC, BWC, DC, AC              registered SRAM write port (WEC and BWC active-low)
//   PENDING                       FIFO non-empty or write in flight (hazard hint)
//   FIFO_COUNT                    current LSU FIFO occupancy
module regfile_wb_arbiter #(
  parameter int unsigned WORD_COUNT   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ZERO_REG_EN  = 1
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ALU_VALID,
  output logic                            ALU_READY,
  input  logic [$clog2(WORD_COUNT)-1:0]   ALU_ADDR,
  input  logic [31:0]                     ALU_DATA,
  input  logic                            LSU_VALID,
  output logic                            LSU_READY,
  input  logic [$clog2(WORD_COUNT)-1:0]   LSU_ADDR,
  input  logic [31:0]                     LSU_DATA,
  input  logic [3:0]                      LSU_BE,
  output logic                            WEC,
  output logic [31:0]                     BWC,
  output logic [31:0]                     DC,
  output logic [$clog2(WORD_COUNT)-1:0]   AC,
  output logic                            PENDING,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);

  localparam int unsigned AW = $clog2(WORD_COUNT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_CNT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ALU,
    SEL_FIFO
  } sel_e;

  // FIFO storage and bookkeeping
  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [3:0]    r_fifo_be   [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;

  // Output registers
  logic          r_wec;
  logic [31:0]   r_bwc;
  logic [31:0]   r_dc;
  logic [AW-1:0] r_ac;

  // Combinational control
  logic          w_nonempty;
  logic          w_starve;
  logic          w_alu_ready;
  logic          w_lsu_ready;
  logic          w_push;
  logic          w_pop;
  sel_e          w_sel;
  logic [AW-1:0] w_head_addr;
  logic [31:0]   w_head_data;
  logic [3:0]    w_head_be;
  logic [31:0]   w_head_bwc;
  logic          w_alu_drop;
  logic          w_head_drop;

  assign w_nonempty  = (r_count != '0);
  assign w_starve    = (r_starve_cnt == LIMIT_CNT);
  assign w_alu_ready = ~w_starve;
  // Ready comes from registered occupancy only. A pop in the same cycle does
  // not open a slot for the incoming request.
  assign w_lsu_ready = (r_count != FULL_CNT);
  assign w_push      = LSU_VALID & w_lsu_ready;

  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_be   = r_fifo_be[r_rd_ptr];

  assign w_alu_drop  = (ZERO_REG_EN != 0) && (ALU_ADDR == '0);
  assign w_head_drop = (ZERO_REG_EN != 0) && (w_head_addr == '0);

  // Priority order: a starved head first, then the ALU, then any queued LSU write.
  always_comb begin
    w_sel = SEL_IDLE;
    if (w_starve && w_nonempty) begin
      w_sel = SEL_FIFO;
    end else if (ALU_VALID && w_alu_ready) begin
      w_sel = SEL_ALU;
    end else if (w_nonempty) begin
      w_sel = SEL_FIFO;
    end
  end

  assign w_pop = (w_sel == SEL_FIFO);

  // Each cleared byte enable sets its 8 mask bits to 1, which masks those bits.
  always_comb begin
    w_head_bwc = '1;
    for (int unsigned i = 0; i < 4; i++) begin
      w_head_bwc[8*i +: 8] = {8{~w_head_be[i]}};
    end
  end

  // Storage needs no reset: an entry is read only after it has been written.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= LSU_ADDR;
      r_fifo_data[r_wr_ptr] <= LSU_DATA;
      r_fifo_be[r_wr_ptr]   <= LSU_BE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The counter measures how long the current head has waited. It restarts on
  // every pop, so the next head gets a full STARVE_LIMIT window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_starve_cnt <= '0;
    end else if (!w_nonempty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT_CNT) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // A dropped register-0 write is still consumed, but WEC stays high and the
  // data, address and mask registers keep their values, as in an idle cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wec <= 1'b1;
      r_bwc <= '1;
      r_dc  <= '0;
      r_ac  <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          if (w_alu_drop) begin
            r_wec <= 1'b1;
          end else begin
            r_wec <= 1'b0;
            r_ac  <= ALU_ADDR;
            r_dc  <= ALU_DATA;
            r_bwc <= '0;
          end
        end
        SEL_FIFO: begin
          if (w_head_drop) begin
            r_wec <= 1'b1;
          end else begin
            r_wec <= 1'b0;
            r_ac  <= w_head_addr;
            r_dc  <= w_head_data;
            r_bwc <= w_head_bwc;
          end
        end
        default: begin
          r_wec <= 1'b1;
        end
      endcase
    end
  end

  assign ALU_READY  = w_alu_ready;
  assign LSU_READY  = w_lsu_ready;
  assign WEC        = r_wec;
  assign BWC        = r_bwc;
  assign DC         = r_dc;
  assign AC         = r_ac;
  assign PENDING    = w_nonempty | ~r_wec;
  assign FIFO_COUNT = r_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 8;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ALU_VALID;
  logic        ALU_READY;
  logic [4:0]  ALU_ADDR;
  logic [31:0] ALU_DATA;
  logic        LSU_VALID;
  logic        LSU_READY;
  logic [4:0]  LSU_ADDR;
  logic [31:0] LSU_DATA;
  logic [3:0]  LSU_BE;
  logic        WEC;
  logic [31:0] BWC;
  logic [31:0] DC;
  logic [4:0]  AC;
  logic        PENDING;
  logic [2:0]  FIFO_COUNT;

  regfile_wb_arbiter #(
    .WORD_COUNT  (32),
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT),
    .ZERO_REG_EN (1)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ALU_VALID (ALU_VALID),
    .ALU_READY (ALU_READY),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .LSU_VALID (LSU_VALID),
    .LSU_READY (LSU_READY),
    .LSU_ADDR  (LSU_ADDR),
    .LSU_DATA  (LSU_DATA),
    .LSU_BE    (LSU_BE),
    .WEC       (WEC),
    .BWC       (BWC),
    .DC        (DC),
    .AC        (AC),
    .PENDING   (PENDING),
    .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  logic        m_wec;
  logic [31:0] m_bwc;
  logic [31:0] m_dc;
  logic [4:0]  m_ac;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (!be[i]) m = m | (32'hFF << (8 * i));
    end
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_wait = 0;
    m_wec  = 1'b1;
    m_bwc  = 32'hFFFF_FFFF;
    m_dc   = 32'h0;
    m_ac   = 5'd0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_wec"},     WEC, m_wec);
    chk({pfx, "_bwc"},     BWC, m_bwc);
    chk({pfx, "_dc"},      DC, m_dc);
    chk({pfx, "_ac"},      AC, m_ac);
    chk({pfx, "_count"},   FIFO_COUNT, q.size());
    chk({pfx, "_pending"}, PENDING, (q.size() > 0) || !m_wec);
  endtask

  // One clock cycle: drive at negedge, check readies, advance model, check after posedge.
  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic [3:0] lb, output logic lsu_taken);
    logic        exp_ardy, exp_lrdy, nonempty, win;
    logic [4:0]  wa;
    logic [31:0] wd, wb;
    ent_t        e;
    @(negedge CLK);
    ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
    LSU_VALID = lv; LSU_ADDR = la; LSU_DATA = ld; LSU_BE = lb;
    #1;
    exp_ardy = (m_wait != LIMIT);
    exp_lrdy = (q.size() != DEPTH);
    chk("alu_ready", ALU_READY, exp_ardy);
    chk("lsu_ready", LSU_READY, exp_lrdy);

    nonempty = (q.size() > 0);
    win = 1'b0; wa = '0; wd = '0; wb = '0;
    if (nonempty && (!exp_ardy || !av)) begin
      e = q.pop_front();
      win = 1'b1; wa = e.a; wd = e.d; wb = mask_of(e.be);
      m_wait = 0;
    end else begin
      if (av && exp_ardy) begin
        win = 1'b1; wa = aa; wd = ad; wb = 32'h0;
      end
      m_wait = nonempty ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    end
    lsu_taken = lv && exp_lrdy;
    if (lsu_taken) q.push_back('{a: la, d: ld, be: lb});
    if (win && wa != 5'd0) begin
      m_wec = 1'b0; m_ac = wa; m_dc = wd; m_bwc = wb;
    end else begin
      m_wec = 1'b1;
    end

    @(posedge CLK);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    logic t;
    int   pushed;
    RESET = 1'b1;
    ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
    LSU_VALID = 1'b0; LSU_ADDR = '0; LSU_DATA = '0; LSU_BE = '0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge CLK);
    RESET = 1'b0;

    // Single ALU write
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, t);
    chk("s1_wec", WEC, 1'b0);
    chk("s1_ac",  AC, 5'd5);
    chk("s1_dc",  DC, 32'hDEADBEEF);
    chk("s1_bwc", BWC, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, t);
    chk("s1_idle_wec", WEC, 1'b1);

    // Single LSU byte write: push, then pop
    cyc(0, 0, 0, 1, 5'd3, 32'h0000AB00, 4'b0010, t);
    chk("s2_count1", FIFO_COUNT, 3'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, t);
    chk("s2_wec",   WEC, 1'b0);
    chk("s2_ac",    AC, 5'd3);
    chk("s2_bwc",   BWC, 32'hFFFF00FF);
    chk("s2_count", FIFO_COUNT, 3'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, t);

    // ALU held busy, five LSU pushes: FIFO fills and the starvation window forces pops
    pushed = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 5'($urandom_range(1, 31)), $urandom, pushed < 5, 5'(10 + pushed),
          32'h1111_0000 + 32'(pushed), 4'hF, t);
      if (t) pushed++;
    end
    while (q.size() > 0) cyc(0, 0, 0, 0, 0, 0, 0, t);

    // Register-0 writes from both sources are consumed without a write
    cyc(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 4'hF, t);
    chk("s4_wec_alu", WEC, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, t);
    chk("s4_wec_lsu", WEC, 1'b1);
    chk("s4_count",   FIFO_COUNT, 3'd0);

    // Zero byte enables: write strobed with a fully masked word
    cyc(0, 0, 0, 1, 5'd7, 32'hCAFEF00D, 4'b0000, t);
    cyc(0, 0, 0, 0, 0, 0, 0, t);
    chk("s5_wec", WEC, 1'b0);
    chk("s5_bwc", BWC, 32'hFFFFFFFF);

    // Fill to 3 under ALU pressure, then push and pop in the same cycle
    for (int i = 0; i < 3; i++) cyc(1, 5'd9, $urandom, 1, 5'(20 + i), $urandom, 4'($urandom), t);
    chk("s6_count3", FIFO_COUNT, 3'd3);
    cyc(0, 0, 0, 1, 5'd23, $urandom, 4'($urandom), t);
    chk("s6_count_hold", FIFO_COUNT, 3'd3);
    chk("s6_lsu_ready",  LSU_READY, 1'b1);
    while (q.size() > 0) cyc(0, 0, 0, 0, 0, 0, 0, t);

    // Fill FIFO, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) cyc(1, 5'd4, $urandom, 1, 5'(i + 1), $urandom, 4'hF, t);
    chk("s7_full", FIFO_COUNT, 3'd4);
    @(negedge CLK);
    ALU_VALID = 1'b0; LSU_VALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_wec",     WEC, 1'b1);
    chk("rst_bwc",     BWC, 32'hFFFFFFFF);
    chk("rst_count",   FIFO_COUNT, 3'd0);
    chk("rst_pending", PENDING, 1'b0);
    chk("rst_dc",      DC, 32'h0);
    chk("rst_ac",      AC, 5'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, t);

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
          $urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
          4'($urandom), t);
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
